// File: rtl/cordic_ln_sequencer.sv
// Control sequencer for an iterative hyperbolic CORDIC natural-log datapath.
// Steps the X/Y/Z registers through iterations 1..ITER_MAX, repeating 4 and 13.
module cordic_ln_sequencer #(
    parameter int ITER_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beg_op,
    input  logic       ack_op,
    input  logic       y_sign,
    output logic       load_sel,
    output logic       enab_reg,
    output logic [3:0] shift_amt,
    output logic       dir,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(ITER_MAX);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rep, rep_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rep   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rep   <= rep_nxt;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default up front so no
        // path through the case leaves a signal unassigned (which would infer a latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_nxt   = rep;
        load_sel  = 1'b0;
        enab_reg  = 1'b0;
        shift_amt = 4'd0;
        dir       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (beg_op) begin
                    state_nxt = LOAD;
                    cnt_nxt   = 4'd0;
                    rep_nxt   = 1'b0;
                end
            end

            LOAD: begin
                enab_reg  = 1'b1;
                busy      = 1'b1;
                state_nxt = ITER;
                cnt_nxt   = 4'd1;
                rep_nxt   = 1'b0;
            end

            ITER: begin
                load_sel  = 1'b1;
                enab_reg  = 1'b1;
                busy      = 1'b1;
                shift_amt = cnt;
                dir       = y_sign;
                // Iterations 4 and 13 run twice so the hyperbolic rotation converges.
                if ((cnt == 4'd4 || cnt == 4'd13) && !rep) begin
                    rep_nxt = 1'b1;
                end else if (cnt == LAST) begin
                    state_nxt = DONE;
                    rep_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    rep_nxt = 1'b0;
                end
            end

            DONE: begin
                load_sel = 1'b1;
                done     = 1'b1;
                if (ack_op) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                rep_nxt   = 1'b0;
            end
        endcase
    end

endmodule
